// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and a constant-function ceil(log2) used to size iteration counters.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SIGN = 2'd2
   } state_t;

   // Smallest r with 2**r >= n; callers only pass n >= 2, so the result is >= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_mult_shift_add_if.sv
// Request/response bundle of the multiplier: operands and start in, busy/done/product out.
interface seq_mult_shift_add_if #(parameter int W = 4);

   logic           start;
   logic           signed_mode;
   logic [W-1:0]   m;
   logic [W-1:0]   q;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;

   modport master (
      output start, signed_mode, m, q,
      input  busy, done, p
   );

   modport slave (
      input  start, signed_mode, m, q,
      output busy, done, p
   );

endinterface

// File: rtl/mult_addshift_step.sv
// One iteration of shift-add multiplication: conditional add of the multiplicand
// into the accumulator, then a one-place right shift of the {acc, qr} pair.
module mult_addshift_step #(
   parameter int W = 4
) (
   input  logic [W:0]   acc,
   input  logic [W-1:0] qr,
   input  logic [W-1:0] mr,
   output logic [W:0]   acc_nxt,
   output logic [W-1:0] qr_nxt
);

   logic [W:0] sum;

   // acc[W] is always zero between steps, so the full-width add equals
   // acc[W-1:0] + addend with the carry landing in sum[W].
   always_comb begin
      // NOTE: every output gets a value on every path so no latch is inferred.
      sum     = '0;
      acc_nxt = '0;
      qr_nxt  = '0;
      sum     = acc + {1'b0, (qr[0] ? mr : {W{1'b0}})};
      acc_nxt = {1'b0, sum[W:1]};
      qr_nxt  = {sum[0], qr[W-1:1]};
   end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier: magnitudes are multiplied over W RUN cycles
// by one reused adder, then the sign is re-applied in a single SIGN cycle.
module seq_mult_shift_add
   import mult_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_mult_shift_add_if.slave  bus
);

   localparam int CW = clog2(W);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [W:0]     acc;
   logic [W-1:0]   qr;
   logic [W-1:0]   mr;
   logic           neg;
   logic           busy_r;
   logic           done_r;
   logic [2*W-1:0] p_r;

   logic [W:0]     acc_nxt;
   logic [W-1:0]   qr_nxt;
   logic [2*W-1:0] mag_prod;

   // The most negative operand maps to 2**(W-1), which still fits W unsigned bits.
   function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sm);
      return (sm && v[W-1]) ? -v : v;
   endfunction

   mult_addshift_step #(.W(W)) u_step (
      .acc     (acc),
      .qr      (qr),
      .mr      (mr),
      .acc_nxt (acc_nxt),
      .qr_nxt  (qr_nxt)
   );

   assign mag_prod = {acc[W-1:0], qr};

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         qr     <= '0;
         mr     <= '0;
         neg    <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         p_r    <= '0;
      end else begin
         done_r <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  mr     <= magnitude(bus.m, bus.signed_mode);
                  qr     <= magnitude(bus.q, bus.signed_mode);
                  neg    <= bus.signed_mode & (bus.m[W-1] ^ bus.q[W-1]);
                  acc    <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc <= acc_nxt;
               qr  <= qr_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) state <= ST_SIGN;
            end
            ST_SIGN: begin
               p_r    <= neg ? -mag_prod : mag_prod;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.p    = p_r;

endmodule
